// File: rtl/pio_hb_pkg.sv
// Shared types and default constants for the dual-core PIO heartbeat monitor.
package pio_hb_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    ALIVE      = 2'd1,
    STALLED    = 2'd2
  } hb_state_t;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000000;
  localparam int unsigned DEF_BLINK_CYCLES   = 12500000;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

endpackage

// File: rtl/hb_channel.sv
// One heartbeat channel: synchronizer, toggle detect, watchdog timer, FSM and
// saturating beat counter.
//
// state      | meaning
// WAIT_FIRST | no beat seen since reset
// ALIVE      | beat seen within the last TIMEOUT_CYCLES cycles
// STALLED    | TIMEOUT_CYCLES cycles elapsed without a beat
module hb_channel
  import pio_hb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             pin,
  input  logic             clear,
  output hb_state_t        state,
  output logic             stall_next,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [TMR_W-1:0]       timer_q;
  logic                   beat;

  // Free-running so the chain is already settled when reset is released.
  always_ff @(posedge clk_clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign beat       = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign stall_next = !beat && (timer_q == TMR_LAST);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state    <= WAIT_FIRST;
      timer_q  <= '0;
      beat_cnt <= '0;
    end else begin
      if (beat) begin
        state   <= ALIVE;
        timer_q <= '0;
      end else if (stall_next) begin
        state   <= STALLED;
      end else begin
        timer_q <= timer_q + TMR_W'(1);
      end

      // Clear takes priority over a coincident beat.
      if (clear) begin
        beat_cnt <= '0;
      end else if (beat && (beat_cnt != {CNT_W{1'b1}})) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_heartbeat_monitor.sv
// Watches the two Nios heartbeat bits on pio0_export, flags stalled cores and
// drives one status LED per core.
module pio_heartbeat_monitor
  import pio_hb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned BLINK_CYCLES   = DEF_BLINK_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       pio0_export,
  input  logic             clear_i,
  output logic [1:0]       led_o,
  output logic [1:0]       alive_o,
  output logic [1:0]       stall_o,
  output logic [1:0]       stall_seen_o,
  output logic [CNT_W-1:0] beat_cnt0_o,
  output logic [CNT_W-1:0] beat_cnt1_o
);

  localparam int unsigned BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  hb_state_t        ch_state [2];
  logic [CNT_W-1:0] ch_cnt   [2];
  logic [1:0]       stall_next;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    hb_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pin           (pio0_export[i]),
      .clear         (clear_i),
      .state         (ch_state[i]),
      .stall_next    (stall_next[i]),
      .beat_cnt      (ch_cnt[i])
    );
  end

  assign beat_cnt0_o = ch_cnt[0];
  assign beat_cnt1_o = ch_cnt[1];

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      stall_seen_o <= 2'b00;
    end else begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLK_W'(1);
      end
      // A stall entering on the same cycle as a clear survives it.
      stall_seen_o <= stall_next | (stall_seen_o & ~{2{clear_i}});
    end
  end

  // Decodes of registered state only; nothing here depends on pio0_export.
  always_comb begin
    led_o   = 2'b00;
    alive_o = 2'b00;
    stall_o = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (ch_state[i])
        ALIVE: begin
          alive_o[i] = 1'b1;
          led_o[i]   = blink_phase;
        end
        STALLED: begin
          stall_o[i] = 1'b1;
          led_o[i]   = 1'b1;
        end
        default: led_o[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_heartbeat_monitor.sv
// Directed and randomized checks of pio_heartbeat_monitor against a
// cycles-since-last-beat reference model.
module tb_pio_heartbeat_monitor;

  localparam int T = 100;
  localparam int B = 10;
  localparam int S = 2;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic [1:0]   pio;
  logic [1:0]   led, alive, stall, sseen;
  logic [W-1:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pin history, cycles since last beat, beat counts.
  logic [1:0] h1, h2, h3;
  int         m_since [2];
  bit         m_seen  [2];
  int         m_cnt   [2];
  bit         m_ss    [2];
  int         m_bcnt;
  bit         m_phase;

  always #5 clk = ~clk;

  pio_heartbeat_monitor #(
    .TIMEOUT_CYCLES (T),
    .BLINK_CYCLES   (B),
    .SYNC_STAGES    (S),
    .CNT_W          (W)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pio0_export   (pio),
    .clear_i       (clr),
    .led_o         (led),
    .alive_o       (alive),
    .stall_o       (stall),
    .stall_seen_o  (sseen),
    .beat_cnt0_o   (cnt0),
    .beat_cnt1_o   (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Effect of the coming rising edge, given the inputs currently driven.
  // A pin sampled at edge n is seen as a beat at edge n+2.
  task automatic model_tick();
    logic [1:0] ev;
    ev = h2 ^ h3;
    h3 = h2;
    h2 = h1;
    h1 = pio;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_since[c] = 0; m_seen[c] = 0; m_cnt[c] = 0; m_ss[c] = 0;
      end
      m_bcnt = 0;
      m_phase = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ev[c]) begin
          m_since[c] = 0;
          m_seen[c] = 1;
        end else if (m_since[c] < T) begin
          m_since[c]++;
        end
        if (m_since[c] >= T) m_ss[c] = 1;
        else if (clr) m_ss[c] = 0;
        if (clr) m_cnt[c] = 0;
        else if (ev[c] && m_cnt[c] < CMAX) m_cnt[c]++;
      end
      if (m_bcnt == B - 1) begin
        m_bcnt = 0;
        m_phase = !m_phase;
      end else begin
        m_bcnt++;
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] e_alive, e_stall, e_led, e_ss;
    for (int c = 0; c < 2; c++) begin
      e_stall[c] = (m_since[c] >= T);
      e_alive[c] = !e_stall[c] && m_seen[c];
      e_led[c]   = e_stall[c] | (e_alive[c] & m_phase);
      e_ss[c]    = m_ss[c];
    end
    chk("alive_o", alive, e_alive);
    chk("stall_o", stall, e_stall);
    chk("led_o", led, e_led);
    chk("stall_seen_o", sseen, e_ss);
    chk("beat_cnt0_o", cnt0, m_cnt[0]);
    chk("beat_cnt1_o", cnt1, m_cnt[1]);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_tick();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic rand_run(input int cycles, input int rate);
    for (int k = 0; k < cycles; k++) begin
      if ($urandom_range(rate - 1) == 0) pio[0] = ~pio[0];
      if ($urandom_range(rate - 1) == 0) pio[1] = ~pio[1];
      clr = ($urandom_range(79) == 0);
      step(1);
    end
    clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " led_o"}, led, 0);
    chk({tag, " alive_o"}, alive, 0);
    chk({tag, " stall_o"}, stall, 0);
    chk({tag, " stall_seen_o"}, sseen, 0);
    chk({tag, " beat_cnt0_o"}, cnt0, 0);
    chk({tag, " beat_cnt1_o"}, cnt1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    pio   = 2'b11;
    h1 = 2'b11; h2 = 2'b11; h3 = 2'b11;

    // 1: static pins, both channels stall exactly T cycles after release
    step(4);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(T - 1);
    chk("pre-timeout stall_o", stall, 2'b00);
    step(1);
    chk("timeout stall_o", stall, 2'b11);
    chk("timeout stall_seen_o", sseen, 2'b11);
    chk("timeout led_o", led, 2'b11);
    chk("static beat_cnt0_o", cnt0, 0);
    chk("static beat_cnt1_o", cnt1, 0);

    // 2: ten toggles on bit 0, three-cycle latency on the first
    for (int i = 0; i < 10; i++) begin
      pio[0] = ~pio[0];
      if (i == 0) begin
        step(2);
        chk("latency-2 alive_o[0]", alive[0], 1'b0);
        step(1);
        chk("latency-3 alive_o[0]", alive[0], 1'b1);
        step(47);
      end else begin
        step(50);
      end
    end
    chk("ten beats beat_cnt0_o", cnt0, 10);
    chk("ch1 still stall_o[1]", stall[1], 1'b1);

    // 3: twenty toggles on bit 1 saturate the counter
    for (int i = 0; i < 20; i++) begin
      pio[1] = ~pio[1];
      step(5);
    end
    step(5);
    chk("saturate beat_cnt1_o", cnt1, CMAX);

    // 4: stall and recover channel 0, then clear the sticky flag
    step(110);
    chk("stalled stall_o[0]", stall[0], 1'b1);
    pio[0] = ~pio[0];
    step(3);
    chk("recover stall_o[0]", stall[0], 1'b0);
    chk("recover alive_o[0]", alive[0], 1'b1);
    chk("recover stall_seen_o[0]", sseen[0], 1'b1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("cleared stall_seen_o[0]", sseen[0], 1'b0);

    // 5: beat lands on the cycle the timer sits at T-1
    pio[0] = ~pio[0];
    step(T);
    pio[0] = ~pio[0];
    step(T + 2);
    chk("edge-at-timeout stall_o[0]", stall[0], 1'b0);
    step(1);
    chk("restarted timeout stall_o[0]", stall[0], 1'b1);

    // 6: clear coincides with a beat at count 5
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pio[0] = ~pio[0];
      step(5);
    end
    step(5);
    chk("five beats beat_cnt0_o", cnt0, 5);
    pio[0] = ~pio[0];
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clear-wins beat_cnt0_o", cnt0, 0);
    chk("clear-wins alive_o[0]", alive[0], 1'b1);

    rand_run(1500, 30);
    rand_run(1500, 150);

    // mid-operation reset
    rst_n = 1'b0;
    step(1);
    chk_all_zero("mid-reset");
    step(3);
    rst_n = 1'b1;
    rand_run(800, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
